display_bitplane_scanner: RTL and testbench

//  Consumer side of display_color_encoder output. Reads one row of encoded

---
 rtl/display_bitplane_scanner.sv | 249 ++++++++++++++++++++++++
 tb/tb_display_bitplane_scanner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/display_bitplane_scanner.sv
// ---------------------------------------------------------------------------
// display_bitplane_scanner
//
// Reads one row of encoded pixels (cpixel words) from a line buffer and
// drives it to an LED panel as binary-coded-modulation bit-planes, LSB
// plane first. For every plane the row is shifted out serially (one column
// per sclk), latched into the panel, and then shown with the LEDs unblanked
// for basecycles<<plane clock cycles.
//
// Parameters
//   segments   panel segments driven in parallel (one pixel per segment per word)
//   cyclewidth bits per colour channel, equal to the number of bit-planes
//   columns    pixels per row (>= 1)
//   basecycles SHOW length of plane 0 in clock cycles (>= 1)
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous reset, active-high; aborts any scan in progress
//   start    in   begin scanning a row; only looked at while idle
//   busy     out  high from the cycle after an accepted start until done
//   done     out  one-cycle pulse when the last plane's SHOW period ends
//   rd_addr  out  line buffer column address (registered)
//   rd_data  in   cpixel word, valid one cycle after rd_addr
//   rgb      out  serial data, bit s*3+{2,1,0} = segment s {R,G,B}
//   sclk     out  shift strobe, high for one cycle while rgb is valid
//   latch    out  one-cycle latch strobe after the last sclk of a plane
//   blank    out  1 = LEDs off
//   plane    out  current bit-plane index
// ---------------------------------------------------------------------------
module display_bitplane_scanner #(
  parameter int segments   = 2,
  parameter int cyclewidth = 10,
  parameter int columns    = 64,
  parameter int basecycles = 1,
  localparam int aw = (columns > 1) ? $clog2(columns) : 1,
  localparam int pw = (cyclewidth > 1) ? $clog2(cyclewidth) : 1,
  localparam int dw = segments * 3 * cyclewidth
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [aw-1:0] rd_addr,
  input  logic [dw-1:0] rd_data,
  output logic [segments*3-1:0] rgb,
  output logic          sclk,
  output logic          latch,
  output logic          blank,
  output logic [pw-1:0] plane
);

  // SHOW counter is wide enough for basecycles << (cyclewidth-1) so it
  // never wraps, even on the longest plane.
  localparam int sw = cyclewidth + $clog2(basecycles + 1);

  localparam logic [aw-1:0] last_col   = aw'(columns - 1);
  localparam logic [pw-1:0] last_plane = pw'(cyclewidth - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_DRAIN0 = 3'd2,
    S_DRAIN1 = 3'd3,
    S_LATCH  = 3'd4,
    S_SHOW   = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic [sw-1:0] show_cnt;
  logic [sw-1:0] show_len;
  logic          shift_valid;

  logic          busy_next;
  logic          done_next;
  logic          blank_next;
  logic          latch_next;
  logic [aw-1:0] rd_addr_next;
  logic [pw-1:0] plane_next;
  logic [segments*3-1:0] rgb_pick;

  // ------------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ------------------------------------------------------------------------
  // FSM next-state logic
  // SHIFT covers the address phase only; the two DRAIN states let the last
  // column travel through the read latency and the rgb register before the
  // latch strobe.
  // ------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_SHIFT;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (rd_addr == last_col) begin
          next_state = S_DRAIN0;
        end else begin
          next_state = S_SHIFT;
        end
      end
      S_DRAIN0: next_state = S_DRAIN1;
      S_DRAIN1: next_state = S_LATCH;
      S_LATCH:  next_state = S_SHOW;
      S_SHOW: begin
        if (show_cnt == '0) begin
          if (plane == last_plane) begin
            next_state = S_IDLE;
          end else begin
            next_state = S_SHIFT;
          end
        end else begin
          next_state = S_SHOW;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // FSM output logic: next values for the registered panel/control outputs
  // are derived from the upcoming state so every output changes together
  // with the state it describes.
  // ------------------------------------------------------------------------
  always_comb begin
    busy_next    = (next_state != S_IDLE);
    blank_next   = (next_state != S_SHOW);
    latch_next   = (next_state == S_LATCH);
    done_next    = (state == S_SHOW) && (next_state == S_IDLE);
    rd_addr_next = rd_addr;
    plane_next   = plane;

    // Column address: restart at 0 on every entry to SHIFT, step while in it.
    if ((next_state == S_SHIFT) && (state != S_SHIFT)) begin
      rd_addr_next = '0;
    end else if ((state == S_SHIFT) && (next_state == S_SHIFT)) begin
      rd_addr_next = rd_addr + aw'(1);
    end else begin
      rd_addr_next = rd_addr;
    end

    // Plane index: cleared on an accepted start, advanced after each SHOW
    // except the last one.
    if ((state == S_IDLE) && (next_state == S_SHIFT)) begin
      plane_next = '0;
    end else if ((state == S_SHOW) && (next_state == S_SHIFT)) begin
      plane_next = plane + pw'(1);
    end else begin
      plane_next = plane;
    end
  end

  // ------------------------------------------------------------------------
  // Registered control outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      blank   <= 1'b1;
      latch   <= 1'b0;
      rd_addr <= '0;
      plane   <= '0;
    end else begin
      busy    <= busy_next;
      done    <= done_next;
      blank   <= blank_next;
      latch   <= latch_next;
      rd_addr <= rd_addr_next;
      plane   <= plane_next;
    end
  end

  // ------------------------------------------------------------------------
  // SHOW length for the current plane (basecycles weighted by 2^plane)
  // ------------------------------------------------------------------------
  always_comb begin
    show_len = sw'(basecycles) << plane;
  end

  // ------------------------------------------------------------------------
  // SHOW down-counter: loaded during LATCH, reaches 0 on the last SHOW cycle
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      show_cnt <= '0;
    end else if (state == S_LATCH) begin
      show_cnt <= show_len - sw'(1);
    end else if ((state == S_SHOW) && (show_cnt != '0)) begin
      show_cnt <= show_cnt - sw'(1);
    end else begin
      show_cnt <= show_cnt;
    end
  end

  // ------------------------------------------------------------------------
  // Bit selection: bit[plane] of every channel in the returned cpixel word.
  // Channel index c = 2/1/0 selects R/G/B, R sitting in the top third of
  // each segment's slice.
  // ------------------------------------------------------------------------
  always_comb begin
    logic [cyclewidth-1:0] chan;
    rgb_pick = '0;
    chan     = '0;
    for (int s = 0; s < segments; s++) begin
      for (int c = 0; c < 3; c++) begin
        chan = rd_data[(s*3 + c)*cyclewidth +: cyclewidth];
        rgb_pick[s*3 + c] = chan[plane];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Shift pipeline: shift_valid marks the cycle in which rd_data belongs to
  // a SHIFT address; rgb/sclk are registered from it one cycle later.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_valid <= 1'b0;
      sclk        <= 1'b0;
      rgb         <= '0;
    end else begin
      shift_valid <= (state == S_SHIFT);
      sclk        <= shift_valid;
      if (shift_valid) begin
        rgb <= rgb_pick;
      end else begin
        rgb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_display_bitplane_scanner.sv
module tb_display_bitplane_scanner;

  localparam int SEG = 2;
  localparam int CW  = 10;
  localparam int C   = 4;
  localparam int B   = 1;
  localparam int DW  = SEG * 3 * CW;
  localparam int TOTAL = CW * (C + 3) + B * ((1 << CW) - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [1:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic [5:0]    rgb;
  logic          sclk;
  logic          latch;
  logic          blank;
  logic [3:0]    plane;

  logic [DW-1:0] lb [C];

  int vectors     = 0;
  int miscompares = 0;
  int sclk_cnt;
  int latch_cnt;
  int busy_cnt;

  always #5 clk = ~clk;

  // Line buffer model: one cycle read latency.
  always @(posedge clk) rd_data <= lb[rd_addr];

  display_bitplane_scanner #(
    .segments(SEG), .cyclewidth(CW), .columns(C), .basecycles(B)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rgb(rgb), .sclk(sclk),
    .latch(latch), .blank(blank), .plane(plane)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected serial bit: segment s, channel ch (2=R,1=G,0=B), bit plane p of column col.
  function automatic logic exp_bit(input int col, input int s, input int ch, input int p);
    logic [DW-1:0] w;
    w = lb[col];
    return w[s*3*CW + ch*CW + p];
  endfunction

  // Runs one scan and checks every cycle against the timing rules:
  // plane p occupies C+3+(B<<p) cycles: addresses at offsets 0..C-1,
  // sclk at 2..C+1 (column offset-2), latch at C+2, SHOW afterwards.
  task automatic run_scan(input bit pulse, input bit glitch, input bit chain, input int abort_plane);
    int p;
    int o;
    logic [5:0] e;
    if (pulse) start = 1'b1;
    sclk_cnt = 0; latch_cnt = 0; busy_cnt = 0;
    for (int n = 1; n <= TOTAL + 1; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == TOTAL + 1) begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("blank_at_done", blank, 1);
        check("sclk_at_done", sclk, 0);
        check("busy_cycles", busy_cnt, TOTAL);
        check("sclk_total", sclk_cnt, C * CW);
        check("latch_total", latch_cnt, CW);
        if (chain) start = 1'b1;
      end else begin
        o = n - 1;
        p = 0;
        while (o >= C + 3 + (B << p)) begin
          o = o - (C + 3 + (B << p));
          p++;
        end
        if (busy)  busy_cnt++;
        if (sclk)  sclk_cnt++;
        if (latch) latch_cnt++;
        check("busy", busy, 1);
        check("done_early", done, 0);
        check("plane", plane, p);
        check("blank", blank, (o < C + 3));
        check("latch", latch, (o == C + 2));
        check("sclk", sclk, (o >= 2 && o <= C + 1));
        if (o < C) check("rd_addr", rd_addr, o);
        if (o >= 2 && o <= C + 1) begin
          e = '0;
          for (int s = 0; s < SEG; s++)
            for (int ch = 0; ch < 3; ch++)
              e[s*3 + ch] = exp_bit(o - 2, s, ch, p);
          check("rgb", rgb, e);
        end
        if (glitch && (n == 2 || (p == 3 && o == C + 4))) start = 1'b1;
        if (p == abort_plane && o == C + 5) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          check("abort_blank", blank, 1);
          check("abort_busy", busy, 0);
          check("abort_plane", plane, 0);
          check("abort_done", done, 0);
          check("abort_sclk", sclk, 0);
          check("abort_latch", latch, 0);
          for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_idle_blank", blank, 1);
          end
          return;
        end
      end
    end
  endtask

  initial begin
    logic [63:0] r;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < C; i++) lb[i] = '0;

    // Reset hold
    repeat (3) @(negedge clk);
    check("rst_blank", blank, 1);
    check("rst_sclk", sclk, 0);
    check("rst_latch", latch, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_plane", plane, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rgb", rgb, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_blank", blank, 1);
    check("idle_busy", busy, 0);

    // seg0 all channels full on, seg1 off
    for (int i = 0; i < C; i++) lb[i] = {30'h0, 10'h3ff, 10'h3ff, 10'h3ff};
    run_scan(1'b1, 1'b0, 1'b0, -1);

    // seg1 R = 0x155, everything else off
    for (int i = 0; i < C; i++) lb[i] = {10'h155, 20'h0, 30'h0};
    run_scan(1'b1, 1'b0, 1'b0, -1);

    // 24*addr pattern: column order visible through the pipeline
    for (int i = 0; i < C; i++) lb[i] = DW'(24 * i);
    run_scan(1'b1, 1'b0, 1'b0, -1);

    // Random data, start pulses while busy, restart in the done cycle
    for (int i = 0; i < C; i++) begin
      r = {$urandom(), $urandom()};
      lb[i] = r[DW-1:0];
    end
    run_scan(1'b1, 1'b1, 1'b1, -1);
    for (int i = 0; i < C; i++) begin
      r = {$urandom(), $urandom()};
      lb[i] = r[DW-1:0];
    end
    run_scan(1'b0, 1'b0, 1'b0, -1);

    // Random data, reset during SHOW of plane 5
    for (int i = 0; i < C; i++) begin
      r = {$urandom(), $urandom()};
      lb[i] = r[DW-1:0];
    end
    run_scan(1'b1, 1'b0, 1'b0, 5);

    // Idle stays quiet
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("final_idle_busy", busy, 0);
      check("final_idle_done", done, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
